// File: rtl/akiko_c2p_dma.sv
// Akiko C2P batch sequencer: streams 32-pixel chunky blocks from memory into the
// C2P port, then drains the planar result and stores each word to its bitplane.
module akiko_c2p_dma #(
  parameter int AW = 23,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] plane_stride,
  input  logic [CW-1:0] block_count,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ack,
  input  logic          cpu_cs,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [4:0]    cpu_addr,
  input  logic [15:0]   cpu_din,
  output logic [15:0]   cpu_dout,
  output logic          cpu_stall,
  output logic          c2p_cs,
  output logic          c2p_rd,
  output logic          c2p_wr,
  output logic [4:0]    c2p_addr,
  output logic [15:0]   c2p_din,
  input  logic [15:0]   c2p_dout
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_STORE = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;
  localparam logic [2:0] ST_FIN   = 3'd7;

  localparam logic [4:0] C2P_PORT = 5'b11100;

  logic [2:0]    state_q, state_d;
  logic [3:0]    w_q, w_d;
  logic [CW-1:0] b_q, b_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [15:0]   load_q, load_d;
  logic [15:0]   store_q, store_d;

  logic [CW-1:0] b_inc;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] plane_off;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] store_addr;
  logic          idle;

  assign idle  = (state_q == ST_IDLE);
  assign b_inc = b_q + {{(CW-1){1'b0}}, 1'b1};
  assign b_ext = AW'(b_q);

  // Planar word w belongs to plane w>>1; w[0] picks the pixel 0-15 / 16-31 half.
  assign plane_off  = AW'(w_q[3:1]) * stride_q;
  assign fetch_addr = src_q + (b_ext << 4) + AW'(w_q);
  assign store_addr = dst_q + plane_off + (b_ext << 1) + AW'(w_q[0]);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    b_d      = b_q;
    count_d  = count_q;
    src_d    = src_q;
    dst_d    = dst_q;
    stride_d = stride_q;
    load_d   = load_q;
    store_d  = store_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d    = src_base;
          dst_d    = dst_base;
          stride_d = plane_stride;
          count_d  = block_count;
          state_d  = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (count_q == '0) begin
          state_d = ST_FIN;
        end else begin
          w_d     = 4'd0;
          b_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          load_d  = mem_rdata;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_q == 4'd15) begin
          w_d     = 4'd0;
          state_d = ST_DRAIN;
        end else begin
          w_d     = w_q + 4'd1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        store_d = c2p_dout;
        state_d = ST_STORE;
      end
      ST_STORE: begin
        if (mem_ack) begin
          if (w_q == 4'd15) begin
            state_d = ST_NEXT;
          end else begin
            w_d     = w_q + 4'd1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_NEXT: begin
        b_d     = b_inc;
        w_d     = 4'd0;
        state_d = (b_inc == count_q) ? ST_FIN : ST_FETCH;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      w_q      <= 4'd0;
      b_q      <= '0;
      count_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      stride_q <= '0;
      load_q   <= 16'd0;
      store_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      b_q      <= b_d;
      count_q  <= count_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      stride_q <= stride_d;
      load_q   <= load_d;
      store_q  <= store_d;
    end
  end

  assign busy      = !idle;
  assign done      = (state_q == ST_FIN);
  assign mem_req   = (state_q == ST_FETCH) || (state_q == ST_STORE);
  assign mem_we    = (state_q == ST_STORE);
  assign mem_addr  = (state_q == ST_STORE) ? store_addr : fetch_addr;
  assign mem_wdata = store_q;

  // While a batch runs the sequencer owns the C2P port and the CPU is held off.
  always_comb begin
    if (idle) begin
      c2p_cs    = cpu_cs;
      c2p_rd    = cpu_rd;
      c2p_wr    = cpu_wr;
      c2p_addr  = cpu_addr;
      c2p_din   = cpu_din;
      cpu_dout  = c2p_dout;
      cpu_stall = 1'b0;
    end else begin
      c2p_rd    = (state_q == ST_PRIME) || (state_q == ST_DRAIN);
      c2p_wr    = (state_q == ST_LOAD);
      c2p_cs    = c2p_rd || c2p_wr;
      c2p_addr  = C2P_PORT;
      c2p_din   = load_q;
      cpu_dout  = 16'd0;
      cpu_stall = cpu_cs && (cpu_rd || cpu_wr);
    end
  end

endmodule

// File: tb/tb_akiko_c2p_dma.sv
// Randomized bench for akiko_c2p_dma: behavioural C2P port and memory, results
// checked against planar words computed directly from the chunky source data.
module tb_akiko_c2p_dma;
  localparam int AW = 23;
  localparam int CW = 16;
  localparam int MASK = 32'h007F_FFFF;
  typedef logic [15:0] blk_t [16];

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_base, dst_base, plane_stride;
  logic [CW-1:0] block_count;
  logic          busy, done, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic          cpu_cs, cpu_rd, cpu_wr, cpu_stall;
  logic [4:0]    cpu_addr, c2p_addr;
  logic [15:0]   cpu_din, cpu_dout, c2p_din, c2p_dout;
  logic          c2p_cs, c2p_rd, c2p_wr;

  always #5 clk = ~clk;

  akiko_c2p_dma #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .plane_stride(plane_stride),
    .block_count(block_count), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .c2p_cs(c2p_cs), .c2p_rd(c2p_rd), .c2p_wr(c2p_wr), .c2p_addr(c2p_addr),
    .c2p_din(c2p_din), .c2p_dout(c2p_dout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Planar word k of a 32-pixel block: plane k>>1, pixels (k&1)*16 .. +15, MSB = first pixel.
  function automatic logic [15:0] planar(input blk_t c, input int k);
    logic [15:0] r;
    logic [7:0]  px;
    int          pix;
    r = 16'h0;
    for (int j = 0; j < 16; j++) begin
      pix = (k & 1) * 16 + j;
      px  = (pix % 2 == 0) ? c[pix / 2][15:8] : c[pix / 2][7:0];
      r[15-j] = px[k >> 1];
    end
    return r;
  endfunction

  logic [15:0] mem [int];

  function automatic logic [15:0] mem_peek(input int a);
    if (mem.exists(a & MASK)) return mem[a & MASK];
    return 16'h0;
  endfunction

  // C2P port model: writes fill the chunky buffer (extra writes dropped),
  // any read resets the write pointer, and reads step through planar words.
  blk_t       cbuf = '{default: 16'h0};
  logic [4:0] wp = 5'd0;
  logic [3:0] rp = 4'd0;

  always @(posedge clk) begin
    if (c2p_cs && c2p_wr) begin
      if (wp < 5'd16) begin
        cbuf[wp[3:0]] <= c2p_din;
        wp <= wp + 5'd1;
      end
      rp <= 4'd0;
    end else if (c2p_cs && c2p_rd) begin
      wp <= 5'd0;
      rp <= rp + 4'd1;
    end
  end

  always_comb c2p_dout = planar(cbuf, int'(rp));

  int max_delay = 0;
  int mem_rd_n = 0, mem_wr_n = 0, addr_viol = 0;

  initial begin
    int wait_cnt;
    logic seen;
    logic [AW-1:0] last;
    wait_cnt = 0; seen = 1'b0; last = '0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
        if (seen && mem_addr !== last) addr_viol++;
        seen = 1'b1;
        last = mem_addr;
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          seen = 1'b0;
          if (mem_we) begin
            mem[int'(mem_addr)] = mem_wdata;
            mem_wr_n++;
          end else begin
            mem_rdata = mem_peek(int'(mem_addr));
            mem_rd_n++;
          end
          wait_cnt = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
        end else begin
          wait_cnt--;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  int c2p_wr_n = 0, c2p_rd_n = 0, done_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (busy && c2p_cs && c2p_wr) c2p_wr_n++;
      if (busy && c2p_cs && c2p_rd) c2p_rd_n++;
      if (done) done_n++;
    end
  end

  int b_wr, b_rd, b_mwr, b_mrd, b_done, b_viol;

  task automatic snapshot();
    b_wr = c2p_wr_n; b_rd = c2p_rd_n; b_mwr = mem_wr_n;
    b_mrd = mem_rd_n; b_done = done_n; b_viol = addr_viol;
  endtask

  task automatic fill(input int src, input int bc, input int mode);
    logic [7:0] hi;
    for (int i = 0; i < bc * 16; i++) begin
      hi = 8'(2 * (i % 16));
      case (mode)
        0:       mem[(src + i) & MASK] = 16'($urandom);
        1:       mem[(src + i) & MASK] = {hi, hi + 8'd1};
        default: mem[(src + i) & MASK] = 16'hFFFF;
      endcase
    end
  endtask

  task automatic launch(input int src, input int dst, input int stride, input int bc);
    @(negedge clk);
    src_base = AW'(src); dst_base = AW'(dst); plane_stride = AW'(stride);
    block_count = CW'(bc);
    start = 1'b1;
    snapshot();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic verify(input string tag, input int src, input int dst, input int stride, input int bc);
    blk_t blk;
    int a;
    check({tag, "_done_n"}, done_n - b_done, 1);
    check({tag, "_mem_rd"}, mem_rd_n - b_mrd, bc * 16);
    check({tag, "_mem_wr"}, mem_wr_n - b_mwr, bc * 16);
    check({tag, "_c2p_wr"}, c2p_wr_n - b_wr, bc * 16);
    check({tag, "_c2p_rd"}, c2p_rd_n - b_rd, bc * 16 + 1);
    check({tag, "_addr_stable"}, addr_viol - b_viol, 0);
    for (int b = 0; b < bc; b++) begin
      for (int w = 0; w < 16; w++) blk[w] = mem_peek(src + b * 16 + w);
      for (int k = 0; k < 16; k++) begin
        a = (dst + (k >> 1) * stride + b * 2 + (k & 1)) & MASK;
        check($sformatf("%s_b%0d_w%0d", tag, b, k), mem_peek(a), planar(blk, k));
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0;
    src_base = '0; dst_base = '0; plane_stride = '0; block_count = '0;
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 5'd0; cpu_din = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_c2p_rd", c2p_rd, 1'b0);
    check("rst_c2p_wr", c2p_wr, 1'b0);
    reset = 1'b0;

    // Ramp pixels: known planar constants.
    fill(32'h2000, 1, 1);
    launch(32'h2000, 32'h1000, 32'h100, 1);
    wait_done("ramp");
    verify("ramp", 32'h2000, 32'h1000, 32'h100, 1);
    check("ramp_1000", mem_peek(32'h1000), 16'h5555);
    check("ramp_1001", mem_peek(32'h1001), 16'h5555);
    check("ramp_1400", mem_peek(32'h1400), 16'h0000);
    check("ramp_1401", mem_peek(32'h1401), 16'hFFFF);

    // Zero blocks: only the priming read, done two cycles after start.
    launch(32'h0, 32'h0, 32'h0, 0);
    check("bc0_prime_rd", c2p_rd, 1'b1);
    check("bc0_prime_addr", c2p_addr, 5'h1C);
    check("bc0_busy", busy, 1'b1);
    check("bc0_no_req", mem_req, 1'b0);
    check("bc0_no_done_yet", done, 1'b0);
    @(negedge clk);
    check("bc0_done", done, 1'b1);
    @(negedge clk);
    check("bc0_done_clear", done, 1'b0);
    check("bc0_idle", busy, 1'b0);
    check("bc0_mem_ops", (mem_rd_n - b_mrd) + (mem_wr_n - b_mwr), 0);
    check("bc0_c2p_rd", c2p_rd_n - b_rd, 1);
    check("bc0_done_n", done_n - b_done, 1);

    // CPU write while the sequencer is fetching.
    fill(32'h3000, 1, 0);
    launch(32'h3000, 32'h5000, 32'h40, 1);
    n = 0;
    while (!(mem_req && !mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_fetch_seen", mem_req && !mem_we, 1'b1);
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'h1C; cpu_din = 16'hABCD;
    #1;
    check("stall_asserted", cpu_stall, 1'b1);
    check("stall_no_c2p_wr", c2p_wr, 1'b0);
    check("stall_dout_zero", cpu_dout, 16'h0);
    wait_done("stall");
    #1;
    check("stall_released", cpu_stall, 1'b0);
    check("stall_pass_wr", c2p_wr, 1'b1);
    check("stall_pass_din", c2p_din, 16'hABCD);
    @(negedge clk);
    cpu_cs = 1'b0; cpu_wr = 1'b0;
    verify("stall", 32'h3000, 32'h5000, 32'h40, 1);

    // Partial CPU writes must be flushed by the priming read.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'h1C; cpu_din = 16'h0000;
    end
    @(negedge clk);
    cpu_cs = 1'b0; cpu_wr = 1'b0;
    fill(32'h6000, 1, 2);
    launch(32'h6000, 32'h7000, 32'h10, 1);
    wait_done("prime");
    verify("prime", 32'h6000, 32'h7000, 32'h10, 1);
    check("prime_7000", mem_peek(32'h7000), 16'hFFFF);
    check("prime_7071", mem_peek(32'h7071), 16'hFFFF);

    // Same data with zero-wait and random-wait acknowledges.
    fill(32'h8000, 3, 0);
    launch(32'h8000, 32'h9000, 32'h80, 3);
    wait_done("zw");
    verify("zw", 32'h8000, 32'h9000, 32'h80, 3);
    max_delay = 5;
    launch(32'h8000, 32'hA000, 32'h80, 3);
    wait_done("rw");
    verify("rw", 32'h8000, 32'hA000, 32'h80, 3);
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 3; b++) begin
        check($sformatf("same_p%0d_b%0d", i, b), mem_peek(32'hA000 + i * 32'h80 + b * 2),
              mem_peek(32'h9000 + i * 32'h80 + b * 2));
      end
    end

    // Address wrap and truncated plane products.
    max_delay = 2;
    fill(32'h7FFFF8, 2, 0);
    launch(32'h7FFFF8, 32'h7FFFF0, 32'h180000, 2);
    wait_done("wrap");
    verify("wrap", 32'h7FFFF8, 32'h7FFFF0, 32'h180000, 2);

    // Reset during a store, then a clean run that ignores a second start.
    max_delay = 3;
    fill(32'hB000, 2, 0);
    launch(32'hB000, 32'hC000, 32'h20, 2);
    n = 0;
    while (!(mem_req && mem_we) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_store_seen", mem_req && mem_we, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", done_n - b_done, 0);
    check("rst_mid_stays_idle", busy, 1'b0);
    launch(32'hB000, 32'hD000, 32'h20, 2);
    repeat (10) @(negedge clk);
    src_base = AW'(32'hE000); dst_base = AW'(32'hE800); block_count = CW'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart");
    verify("restart", 32'hB000, 32'hD000, 32'h20, 2);
    max_delay = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
